// File: rtl/irq_controller_prio.sv
// ---------------------------------------------------------------------------
// irq_controller_prio
//
// Purpose:
//   Multi-source priority interrupt controller sitting between peripherals,
//   the CSR unit and the core's trap logic. Each source is either level or
//   rising-edge triggered. A source can be taken when its mie bit is set and
//   the global enable is set. The lowest pending index wins. The controller
//   tracks whether an exception was taken inside an interrupt handler, so the
//   interrupt context survives the nested exception.
//
// Ports:
//   clk_i          clock
//   rst_i          synchronous active-high reset
//   exception_i    synchronous exception being taken this cycle
//   irq_req_i      raw interrupt request lines (N_IRQ)
//   irq_mask_i     per-source enables, mie CSR bits (N_IRQ)
//   mie_i          global interrupt enable (mstatus.MIE)
//   mret_i         mret executing this cycle
//   irq_o          take the interrupt trap this cycle
//   irq_cause_o    mcause value for the interrupt (32)
//   irq_ack_o      one-hot acknowledge, pulsed together with irq_o (N_IRQ)
//   irq_pending_o  pending vector, unmasked (mip read value) (N_IRQ)
//   irq_ret_o      return from the interrupt handler
// ---------------------------------------------------------------------------
module irq_controller_prio #(
   parameter int          N_IRQ      = 16,
   parameter logic [15:0] EDGE_MASK  = 16'h0000,
   parameter int          CAUSE_BASE = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             exception_i,
   input  logic [N_IRQ-1:0] irq_req_i,
   input  logic [N_IRQ-1:0] irq_mask_i,
   input  logic             mie_i,
   input  logic             mret_i,
   output logic             irq_o,
   output logic [31:0]      irq_cause_o,
   output logic [N_IRQ-1:0] irq_ack_o,
   output logic [N_IRQ-1:0] irq_pending_o,
   output logic             irq_ret_o
);

   localparam logic [N_IRQ-1:0] EDGE_SRC    = EDGE_MASK[N_IRQ-1:0];
   localparam logic [31:0]      CAUSE_RESET = 32'h8000_0000 | 32'(CAUSE_BASE);

   // Two independent flags encoded as states: inside an interrupt handler,
   // inside an exception handler, or an exception nested in an interrupt.
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      IRQ     = 2'd1,
      EXC     = 2'd2,
      IRQ_EXC = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [N_IRQ-1:0] pend_edge_q, pend_edge_d;
   logic [N_IRQ-1:0] req_prev_q, req_prev_d;
   logic [31:0]      cause_q, cause_d;

   logic [N_IRQ-1:0] pend;
   logic [N_IRQ-1:0] eligible;
   logic [N_IRQ-1:0] sel_onehot;
   logic [4:0]       sel;
   logic             exc_eff;
   logic             irq_take;
   logic [N_IRQ-1:0] ack;
   logic [31:0]      cause_now;

   // Pending vector and priority selection. Level sources follow the request
   // line directly; edge sources come from the stored pend register. The
   // loop runs from the top down so the lowest eligible index is kept last.
   always_comb begin
      pend       = (pend_edge_q & EDGE_SRC) | (irq_req_i & ~EDGE_SRC);
      eligible   = pend & irq_mask_i;
      sel        = '0;
      sel_onehot = '0;
      for (int i = N_IRQ - 1; i >= 0; i--) begin
         if (eligible[i]) begin
            sel        = 5'(i);
            sel_onehot = '0;
            sel_onehot[i] = 1'b1;
         end
      end
   end

   // Trap decision. Reset is folded in so that nothing is taken or returned
   // while the block is being reset, even if it was mid-handler.
   always_comb begin
      exc_eff   = exception_i || (state_q == EXC) || (state_q == IRQ_EXC);
      irq_take  = !rst_i && (state_q == IDLE) && !exception_i && mie_i && (|eligible);
      ack       = irq_take ? sel_onehot : '0;
      cause_now = 32'h8000_0000 | (32'(CAUSE_BASE) + {27'b0, sel});
      cause_d   = irq_take ? cause_now : cause_q;
   end

   // Edge capture. A fresh rising edge in the same cycle as the ack must not
   // be lost, so the set term is ORed in after the ack clear.
   always_comb begin
      pend_edge_d = ((pend_edge_q & ~ack) | (irq_req_i & ~req_prev_q)) & EDGE_SRC;
      req_prev_d  = irq_req_i;
   end

   // Handler nesting. An exception always takes priority over an mret in the
   // same cycle; a repeated exception inside EXC/IRQ_EXC does not add depth.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (exception_i)   state_d = EXC;
            else if (irq_take) state_d = IRQ;
         end
         IRQ: begin
            if (exception_i)   state_d = IRQ_EXC;
            else if (mret_i)   state_d = IDLE;
         end
         EXC: begin
            if (!exception_i && mret_i) state_d = IDLE;
         end
         IRQ_EXC: begin
            if (!exception_i && mret_i) state_d = IRQ;
         end
         default: state_d = IDLE;
      endcase
   end

   // All state registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         pend_edge_q <= '0;
         req_prev_q  <= '0;
         cause_q     <= CAUSE_RESET;
      end else begin
         state_q     <= state_d;
         pend_edge_q <= pend_edge_d;
         req_prev_q  <= req_prev_d;
         cause_q     <= cause_d;
      end
   end

   // The cause is shown live while trapping and held afterwards, so the CSR
   // unit can read it at any point during the handler.
   always_comb begin
      irq_o         = irq_take;
      irq_ack_o     = ack;
      irq_cause_o   = irq_take ? cause_now : cause_q;
      irq_pending_o = rst_i ? '0 : pend;
      irq_ret_o     = !rst_i && mret_i && !exc_eff;
   end

endmodule

// File: tb/tb_irq_controller_prio.sv
// ---------------------------------------------------------------------------
// tb_irq_controller_prio
//
// Directed bench for irq_controller_prio with source 0 edge triggered and all
// other sources level triggered. Each step drives inputs just after a rising
// edge and pushes the expected outputs onto a scoreboard queue; the entry is
// popped and compared on the following falling edge.
// ---------------------------------------------------------------------------
module tb_irq_controller_prio;

   logic        clk;
   logic        rst;
   logic        exception;
   logic [15:0] irqReq;
   logic [15:0] irqMask;
   logic        mie;
   logic        mret;
   logic        irqOut;
   logic [31:0] irqCause;
   logic [15:0] irqAck;
   logic [15:0] irqPending;
   logic        irqRet;

   int errors = 0;
   int checks = 0;

   typedef struct {
      string       tag;
      logic        irq;
      logic [31:0] cause;
      logic [15:0] ack;
      logic [15:0] pend;
      logic        ret;
   } expect_t;

   expect_t scoreboard[$];

   irq_controller_prio #(
      .N_IRQ      (16),
      .EDGE_MASK  (16'h0001),
      .CAUSE_BASE (16)
   ) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .exception_i   (exception),
      .irq_req_i     (irqReq),
      .irq_mask_i    (irqMask),
      .mie_i         (mie),
      .mret_i        (mret),
      .irq_o         (irqOut),
      .irq_cause_o   (irqCause),
      .irq_ack_o     (irqAck),
      .irq_pending_o (irqPending),
      .irq_ret_o     (irqRet)
   );

   // Free-running 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // One comparison: bumps the check count and reports a mismatch.
   task automatic checkField(input string tag, input string field,
                             input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s.%s observed=%h expected=%h", tag, field, observed, expected);
      end
   endtask

   // Drive one cycle of inputs just after the rising edge and queue the
   // outputs that must be visible during that cycle.
   task automatic applyStimulus(input string tag, input logic r, input logic [15:0] req,
                                input logic [15:0] mask, input logic m, input logic exc,
                                input logic ret, input logic eIrq, input logic [31:0] eCause,
                                input logic [15:0] eAck, input logic [15:0] ePend,
                                input logic eRet);
      expect_t e;
      @(posedge clk);
      #1;
      rst       = r;
      irqReq    = req;
      irqMask   = mask;
      mie       = m;
      exception = exc;
      mret      = ret;
      e.tag   = tag;
      e.irq   = eIrq;
      e.cause = eCause;
      e.ack   = eAck;
      e.pend  = ePend;
      e.ret   = eRet;
      scoreboard.push_back(e);
   endtask

   // Pop the oldest expectation and compare on the falling edge.
   task automatic checkOutput();
      expect_t e;
      @(negedge clk);
      checks++;
      assert (scoreboard.size() > 0)
      else begin
         errors++;
         $error("[TB] FAIL scoreboard observed=empty expected=entry");
      end
      if (scoreboard.size() > 0) begin
         e = scoreboard.pop_front();
         checkField(e.tag, "irq",   {31'b0, irqOut}, {31'b0, e.irq});
         checkField(e.tag, "cause", irqCause,        e.cause);
         checkField(e.tag, "ack",   {16'b0, irqAck}, {16'b0, e.ack});
         checkField(e.tag, "pend",  {16'b0, irqPending}, {16'b0, e.pend});
         checkField(e.tag, "ret",   {31'b0, irqRet}, {31'b0, e.ret});
      end
   endtask

   task automatic step(input string tag, input logic r, input logic [15:0] req,
                       input logic [15:0] mask, input logic m, input logic exc,
                       input logic ret, input logic eIrq, input logic [31:0] eCause,
                       input logic [15:0] eAck, input logic [15:0] ePend, input logic eRet);
      applyStimulus(tag, r, req, mask, m, exc, ret, eIrq, eCause, eAck, ePend, eRet);
      checkOutput();
   endtask

   // Directed sequence. Columns: rst, req, mask, mie, exc, mret | irq, cause, ack, pend, ret.
   initial begin
      rst = 1'b1; irqReq = '0; irqMask = '0; mie = 1'b0; exception = 1'b0; mret = 1'b0;

      step("reset0", 1, 16'h0000, 16'h0000, 0, 0, 0, 0, 32'h8000_0010, 16'h0000, 16'h0000, 0);
      step("reset1", 1, 16'h0000, 16'hFFFF, 1, 0, 0, 0, 32'h8000_0010, 16'h0000, 16'h0000, 0);

      // Level source 3 taken in the same cycle, cause held in the handler.
      step("lvl3_take", 0, 16'h0008, 16'hFFFF, 1, 0, 0, 1, 32'h8000_0013, 16'h0008, 16'h0008, 0);
      step("lvl3_hold", 0, 16'h0008, 16'hFFFF, 1, 0, 0, 0, 32'h8000_0013, 16'h0000, 16'h0008, 0);
      step("lvl3_mret", 0, 16'h0000, 16'hFFFF, 1, 0, 1, 0, 32'h8000_0013, 16'h0000, 16'h0000, 1);

      // Priority: sources 2 and 5 pending, 2 wins; retaken after mret.
      step("prio_take", 0, 16'h0024, 16'hFFFF, 1, 0, 0, 1, 32'h8000_0012, 16'h0004, 16'h0024, 0);
      step("prio_mret", 0, 16'h0024, 16'hFFFF, 1, 0, 1, 0, 32'h8000_0012, 16'h0000, 16'h0024, 1);
      step("prio_again",0, 16'h0024, 16'hFFFF, 1, 0, 0, 1, 32'h8000_0012, 16'h0004, 16'h0024, 0);
      step("prio_mret2",0, 16'h0000, 16'hFFFF, 1, 0, 1, 0, 32'h8000_0012, 16'h0000, 16'h0000, 1);

      // Edge source 0 pulsed with mie low, held pending, taken when mie rises.
      step("edge_pulse",0, 16'h0001, 16'hFFFF, 0, 0, 0, 0, 32'h8000_0012, 16'h0000, 16'h0000, 0);
      step("edge_pend", 0, 16'h0000, 16'hFFFF, 0, 0, 0, 0, 32'h8000_0012, 16'h0000, 16'h0001, 0);
      step("edge_held", 0, 16'h0000, 16'hFFFF, 0, 0, 0, 0, 32'h8000_0012, 16'h0000, 16'h0001, 0);
      step("edge_take", 0, 16'h0000, 16'hFFFF, 1, 0, 0, 1, 32'h8000_0010, 16'h0001, 16'h0001, 0);
      step("edge_clr",  0, 16'h0000, 16'hFFFF, 1, 0, 0, 0, 32'h8000_0010, 16'h0000, 16'h0000, 0);

      // Exception nested inside the interrupt handler.
      step("nest_exc",  0, 16'h0000, 16'hFFFF, 1, 1, 0, 0, 32'h8000_0010, 16'h0000, 16'h0000, 0);
      step("nest_mret1",0, 16'h0000, 16'hFFFF, 1, 0, 1, 0, 32'h8000_0010, 16'h0000, 16'h0000, 0);
      step("nest_mret2",0, 16'h0000, 16'hFFFF, 1, 0, 1, 0, 32'h8000_0010, 16'h0000, 16'h0000, 1);

      // Exception beats an eligible request; exception also beats mret.
      step("exc_block", 0, 16'h0002, 16'hFFFF, 1, 1, 0, 0, 32'h8000_0010, 16'h0000, 16'h0002, 0);
      step("exc_vs_ret",0, 16'h0002, 16'hFFFF, 1, 1, 1, 0, 32'h8000_0010, 16'h0000, 16'h0002, 0);
      step("exc_mret",  0, 16'h0002, 16'hFFFF, 1, 0, 1, 0, 32'h8000_0010, 16'h0000, 16'h0002, 0);
      step("exc_after", 0, 16'h0002, 16'hFFFF, 1, 0, 0, 1, 32'h8000_0011, 16'h0002, 16'h0002, 0);
      step("exc_done",  0, 16'h0000, 16'hFFFF, 1, 0, 1, 0, 32'h8000_0011, 16'h0000, 16'h0000, 1);

      // New rising edge on source 0 in the same cycle as its ack.
      step("re_rise1",  0, 16'h0001, 16'hFFFF, 0, 0, 0, 0, 32'h8000_0011, 16'h0000, 16'h0000, 0);
      step("re_low",    0, 16'h0000, 16'hFFFF, 0, 0, 0, 0, 32'h8000_0011, 16'h0000, 16'h0001, 0);
      step("re_ackrise",0, 16'h0001, 16'hFFFF, 1, 0, 0, 1, 32'h8000_0010, 16'h0001, 16'h0001, 0);
      step("re_kept",   0, 16'h0000, 16'hFFFF, 1, 0, 0, 0, 32'h8000_0010, 16'h0000, 16'h0001, 0);
      step("re_mret",   0, 16'h0000, 16'hFFFF, 1, 0, 1, 0, 32'h8000_0010, 16'h0000, 16'h0001, 1);
      step("re_second", 0, 16'h0000, 16'hFFFF, 1, 0, 0, 1, 32'h8000_0010, 16'h0001, 16'h0001, 0);
      step("re_mret2",  0, 16'h0000, 16'hFFFF, 1, 0, 1, 0, 32'h8000_0010, 16'h0000, 16'h0000, 1);

      // Per-source mask and global enable suppress; mask shifts priority.
      step("mask_off",  0, 16'h0008, 16'hFFF7, 1, 0, 0, 0, 32'h8000_0010, 16'h0000, 16'h0008, 0);
      step("mie_off",   0, 16'h0008, 16'hFFFF, 0, 0, 0, 0, 32'h8000_0010, 16'h0000, 16'h0008, 0);
      step("mask_prio", 0, 16'h0024, 16'hFFFB, 1, 0, 0, 1, 32'h8000_0015, 16'h0020, 16'h0024, 0);

      // Reset inside the handler: no return pulse, state back to IDLE.
      step("rst_mid",   1, 16'h0000, 16'hFFFF, 1, 0, 1, 0, 32'h8000_0015, 16'h0000, 16'h0000, 0);
      step("rst_after", 0, 16'h0000, 16'hFFFF, 1, 0, 0, 0, 32'h8000_0010, 16'h0000, 16'h0000, 0);
      step("stray_mret",0, 16'h0000, 16'hFFFF, 1, 0, 1, 0, 32'h8000_0010, 16'h0000, 16'h0000, 1);
      step("post_rst",  0, 16'h0008, 16'hFFFF, 1, 0, 0, 1, 32'h8000_0013, 16'h0008, 16'h0008, 0);

      // Highest index source.
      step("top_mret",  0, 16'h8000, 16'hFFFF, 1, 0, 1, 0, 32'h8000_0013, 16'h0000, 16'h8000, 1);
      step("top_take",  0, 16'h8000, 16'hFFFF, 1, 0, 0, 1, 32'h8000_001F, 16'h8000, 16'h8000, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/irq_controller_prio.md
Name: irq_controller_prio

Overview:
- Parametrised multi-source successor of the single-line interrupt controller. Sits between peripherals, the CSR unit and the core's trap logic.
- Accepts N_IRQ request lines, each configurable as level or edge, gated by a per-source mask from the mie CSR and by the global mie bit.
- Picks the highest-priority pending source (lowest index wins) and signals a trap with the matching mcause.
- Tracks exception/interrupt nesting, so an exception taken inside an interrupt handler does not lose the interrupt context.

Parameters:
- N_IRQ, 16, number of interrupt sources (1..16).
- EDGE_MASK, 16'h0000, bit i = 1: source i is rising-edge triggered; bit i = 0: level triggered.
- CAUSE_BASE, 16, mcause code of source 0; source i reports CAUSE_BASE+i.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- exception_i  in  1  synchronous exception being taken this cycle
- irq_req_i  in  N_IRQ  raw interrupt request lines
- irq_mask_i  in  N_IRQ  per-source enable (mie CSR bits)
- mie_i  in  1  global interrupt enable (mstatus.MIE)
- mret_i  in  1  mret executing this cycle
- irq_o  out  1  take interrupt trap this cycle
- irq_cause_o  out  32  mcause value for the interrupt
- irq_ack_o  out  N_IRQ  one-hot acknowledge, pulsed with irq_o
- irq_pending_o  out  N_IRQ  pending vector (mip read value)
- irq_ret_o  out  1  return from interrupt handler

Behaviour:
- Reset:
  - State IDLE.
  - Pending register 0; previous-request sample register 0.
  - Latched cause = 0x8000_0000 | CAUSE_BASE.
  - All outputs 0 except irq_cause_o = latched cause.
- Pending, edge source i:
  - pend_i sets on irq_req_i[i] = 1 while the previous sample = 0.
  - pend_i clears on irq_ack_o[i].
  - Set wins when a set and a clear hit the same cycle.
- Pending, level source i: pend_i = irq_req_i[i] combinationally; nothing stored.
- irq_pending_o = pend vector, unmasked.
- eligible = pend & irq_mask_i.
- sel = lowest index with eligible set.
- FSM states (two flags): IDLE, IRQ, EXC, IRQ_EXC.
- exc_eff = exception_i, or state in {EXC, IRQ_EXC}.
- irq_o (combinational) = state IDLE & !exception_i & mie_i & |eligible. Zero latency from request to trap for level sources; one cycle for edge sources (pend register).
- irq_ack_o = irq_o ? onehot(sel) : 0.
- irq_cause_o:
  - While irq_o: 0x8000_0000 | (CAUSE_BASE+sel).
  - Otherwise: the latched cause, captured on irq_o.
- Transitions:
  - IDLE: exception_i -> EXC; else irq_o -> IRQ.
  - IRQ: exception_i -> IRQ_EXC; else mret_i -> IDLE.
  - EXC: mret_i -> IDLE. An exception_i in EXC keeps EXC (no nesting depth counted).
  - IRQ_EXC: mret_i -> IRQ. An exception_i keeps IRQ_EXC.
- exception_i and mret_i in the same cycle: exception wins. No return, no mret transition.
- irq_ret_o = mret_i & !exc_eff. It is high on mret from IRQ, and also on a stray mret in IDLE (state unchanged).
- No interrupt is taken in IRQ, EXC or IRQ_EXC; requests stay pending until IDLE.
- Level source deasserted before IDLE: it is simply lost, no ack.
- irq_mask_i or mie_i dropping while a source is pending: the pend bit is held (edge), and the trap is suppressed.
- rst_i mid-handler: everything returns to reset values next edge; no irq_ret_o is generated.

Test Plan:
- Reset, then level req[3] = 1, mask = 16'hFFFF, mie = 1 -> irq_o = 1 same cycle, cause 0x8000_0013, ack = 16'h0008; next cycle irq_o = 0, state IRQ, cause holds 0x8000_0013.
- req = 16'h0024 level with mask = 16'hFFFF -> sel = 2, cause 0x8000_0012. Then mret -> irq_ret_o = 1, IDLE. Next cycle irq_o = 1 again with cause 0x8000_0012 (req[2] still high).
- EDGE_MASK = 16'h0001, pulse req[0] for 1 cycle with mie = 0 -> pending_o[0] = 1 held. Raise mie -> irq_o next cycle with cause 0x8000_0010, ack[0] clears pending.
- In IRQ, exception_i = 1 -> IRQ_EXC. mret -> irq_ret_o = 0, back to IRQ. Second mret -> irq_ret_o = 1, IDLE.
- IDLE with exception_i = 1 and req[1] eligible in the same cycle -> irq_o = 0, EXC. mret -> IDLE, irq_ret_o = 0. Interrupt taken the following cycle.
- Edge source: new rising edge in the same cycle as its ack -> pend stays 1, and a second trap follows after mret.
